// File: rtl/product_accumulator_8bits_if.sv
// Handshake bundle between the product producer, the accumulator and the
// result consumer. The slave view belongs to the accumulator; the master view
// belongs to whoever feeds products and takes results.
interface product_accumulator_8bits_if #(
  parameter int PROD_W    = 8,
  parameter int ACC_W     = 16,
  parameter int MAX_TERMS = 16
);
  localparam int CNT_W = $clog2(MAX_TERMS) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] prod_num;
  logic              in_last;
  logic              clr;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_num;
  logic [CNT_W-1:0]  term_cnt;
  logic              ovf;

  modport slave (
    input  in_valid, prod_num, in_last, clr, out_ready,
    output in_ready, out_valid, acc_num, term_cnt, ovf
  );

  modport master (
    output in_valid, prod_num, in_last, clr, out_ready,
    input  in_ready, out_valid, acc_num, term_cnt, ovf
  );
endinterface

// File: rtl/product_accumulator_8bits.sv
// Signed dot-product accumulator for the 4x4 multiplier's 8-bit products.
// Beats are summed until in_last or MAX_TERMS beats, then the result is held
// until the consumer takes it (one bubble cycle on the handshake).
// Optional feature: define SATURATE_EN to clamp each add to the ACC_W signed
// range and report a sticky overflow on ovf; otherwise sums wrap and ovf is 0.
module product_accumulator_8bits #(
  parameter int PROD_W    = 8,
  parameter int ACC_W     = 16,
  parameter int MAX_TERMS = 16
) (
  input  logic clk,
  input  logic rst,
  product_accumulator_8bits_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_TERMS) + 1;

  typedef enum logic {S_ACC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_base, prod_ext, acc_next;
  logic [CNT_W-1:0] cnt_q, cnt_base, cnt_next;
  logic [ACC_W-1:0] acc_num_q;
  logic [CNT_W-1:0] term_cnt_q;
  logic             beat, close, hshk, clr_only;

  // Handshake decode straight from the state register, so in_ready never
  // depends combinationally on out_ready.
  assign bus.in_ready  = (state_q == S_ACC);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.acc_num   = acc_num_q;
  assign bus.term_cnt  = term_cnt_q;

  assign beat     = bus.in_valid && (state_q == S_ACC);
  assign hshk     = bus.out_ready && (state_q == S_DONE);
  assign clr_only = bus.clr && !bus.in_valid && (state_q == S_ACC);

  // A clr arriving with a beat makes that beat the first term of a fresh sum.
  assign acc_base = bus.clr ? '0 : acc_q;
  assign cnt_base = bus.clr ? '0 : cnt_q;
  assign cnt_next = cnt_base + 1'b1;
  assign prod_ext = {{(ACC_W-PROD_W){bus.prod_num[PROD_W-1]}}, bus.prod_num};
  assign close    = bus.in_last || (cnt_base == CNT_W'(MAX_TERMS - 1));

`ifdef SATURATE_EN
  logic [ACC_W:0] sum_wide;
  logic           sat_hit, flag_q, flag_next, ovf_q;

  // One guard bit detects signed overflow; clamp to the nearest rail.
  always_comb begin
    sum_wide = {acc_base[ACC_W-1], acc_base} + {prod_ext[ACC_W-1], prod_ext};
    sat_hit  = 1'b0;
    acc_next = sum_wide[ACC_W-1:0];
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      sat_hit  = 1'b1;
      acc_next = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  assign flag_next = (bus.clr ? 1'b0 : flag_q) | sat_hit;
  assign bus.ovf   = ovf_q;

  // Sticky clamp flag for the vector in flight; latched into ovf on close.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (hshk || clr_only) begin
      flag_q <= 1'b0;
    end else if (beat) begin
      flag_q <= flag_next;
      if (close) ovf_q <= flag_next;
    end
  end
`else
  assign acc_next = acc_base + prod_ext;
  assign bus.ovf  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_ACC;
    else     state_q <= state_d;
  end

  // Next state: close on a qualifying beat, reopen on the result handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ACC:   if (beat && close) state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_ACC;
      default: state_d = S_ACC;
    endcase
  end

  // Running sum, term count and the held result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      acc_num_q  <= '0;
      term_cnt_q <= '0;
    end else if (hshk || clr_only) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (beat) begin
      acc_q <= acc_next;
      cnt_q <= cnt_next;
      if (close) begin
        acc_num_q  <= acc_next;
        term_cnt_q <= cnt_next;
      end
    end
  end
endmodule

// File: tb/tb_product_accumulator_8bits.sv
// Directed bench for product_accumulator_8bits: a 16-bit instance for the
// handshake/arithmetic cases and a 10-bit instance for the wrap/clamp case.
module tb_product_accumulator_8bits;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  product_accumulator_8bits_if #(.PROD_W(8), .ACC_W(16), .MAX_TERMS(16)) b();
  product_accumulator_8bits_if #(.PROD_W(8), .ACC_W(10), .MAX_TERMS(16)) b10();

  product_accumulator_8bits #(.PROD_W(8), .ACC_W(16), .MAX_TERMS(16)) dut (
    .clk(clk), .rst(rst), .bus(b)
  );
  product_accumulator_8bits #(.PROD_W(8), .ACC_W(10), .MAX_TERMS(16)) dut10 (
    .clk(clk), .rst(rst), .bus(b10)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat, waiting (bounded) for in_ready, and hold it one edge.
  task automatic send(input logic [7:0] d, input logic last, input logic c);
    int n = 0;
    while (!b.in_ready && n < 50) begin
      tick();
      n++;
    end
    total++;
    assert (n < 50) else begin
      bad++;
      $error("FAIL send_timeout: waited %0d want <50", n);
    end
    b.in_valid = 1'b1;
    b.prod_num = d;
    b.in_last  = last;
    b.clr      = c;
    tick();
    b.in_valid = 1'b0;
    b.in_last  = 1'b0;
    b.clr      = 1'b0;
  endtask

  initial begin
    b.in_valid = 0; b.prod_num = 0; b.in_last = 0; b.clr = 0; b.out_ready = 0;
    b10.in_valid = 0; b10.prod_num = 0; b10.in_last = 0; b10.clr = 0; b10.out_ready = 0;

    // 1. reset
    tick(); tick();
    chk("rst_in_ready",  b.in_ready,  1);
    chk("rst_out_valid", b.out_valid, 0);
    chk("rst_acc",       b.acc_num,   16'h0000);
    chk("rst_cnt",       b.term_cnt,  0);
    chk("rst_ovf",       b.ovf,       0);
    rst = 1'b0;

    // 2. short vector, consumer always ready
    b.out_ready = 1'b1;
    send(8'h06, 0, 0);
    chk("t2_no_early_valid", b.out_valid, 0);
    send(8'hFA, 0, 0);
    send(8'h31, 1, 0);
    chk("t2_valid", b.out_valid, 1);
    chk("t2_acc",   b.acc_num,   16'h0031);
    chk("t2_cnt",   b.term_cnt,  3);
    chk("t2_ovf",   b.ovf,       0);
    tick();
    chk("t2_valid_one_cycle", b.out_valid, 0);
    chk("t2_ready_back",      b.in_ready,  1);

    // 3. forced close after 16 beats
    b.out_ready = 1'b0;
    for (int i = 0; i < 15; i++) send(8'h80, 0, 0);
    chk("t3_open_at_15", b.out_valid, 0);
    send(8'h80, 0, 0);
    chk("t3_valid",   b.out_valid, 1);
    chk("t3_acc",     b.acc_num,   16'hF800);
    chk("t3_cnt",     b.term_cnt,  16);
    chk("t3_held_off", b.in_ready, 0);

    // 4. result held with a beat pending and the consumer stalled
    b.in_valid = 1'b1;
    b.prod_num = 8'h80;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_acc_stable", b.acc_num,  16'hF800);
      chk("t4_cnt_stable", b.term_cnt, 16);
      chk("t4_not_ready",  b.in_ready, 0);
    end
    b.in_valid  = 1'b0;
    b.out_ready = 1'b1;
    tick();
    chk("t4_ready_back", b.in_ready,  1);
    chk("t4_valid_drop", b.out_valid, 0);
    b.out_ready = 1'b0;
    send(8'h01, 1, 0);
    chk("t4_acc", b.acc_num,  16'h0001);
    chk("t4_cnt", b.term_cnt, 1);
    b.out_ready = 1'b1;
    tick();
    b.out_ready = 1'b0;

    // 5. clr with a beat, clr alone, reset mid-vector
    send(8'h10, 0, 0);
    send(8'h10, 0, 0);
    send(8'h05, 0, 1);
    send(8'h02, 1, 0);
    chk("t5_clr_beat_acc", b.acc_num,  16'h0007);
    chk("t5_clr_beat_cnt", b.term_cnt, 2);
    b.out_ready = 1'b1; tick(); b.out_ready = 1'b0;

    send(8'h40, 0, 0);
    b.clr = 1'b1;
    tick();
    b.clr = 1'b0;
    send(8'h05, 1, 0);
    chk("t5_clr_only_acc", b.acc_num,  16'h0005);
    chk("t5_clr_only_cnt", b.term_cnt, 1);
    b.out_ready = 1'b1; tick(); b.out_ready = 1'b0;

    send(8'h20, 0, 0);
    send(8'h20, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_ready", b.in_ready,  1);
    chk("t5_rst_valid", b.out_valid, 0);
    chk("t5_rst_acc",   b.acc_num,   16'h0000);
    chk("t5_rst_cnt",   b.term_cnt,  0);
    send(8'h03, 1, 0);
    chk("t5_fresh_acc", b.acc_num,  16'h0003);
    chk("t5_fresh_cnt", b.term_cnt, 1);
    b.out_ready = 1'b1; tick(); b.out_ready = 1'b0;

    // 6. 10-bit accumulator, 16 x 127 = 2032
    for (int i = 0; i < 16; i++) begin
      b10.in_valid = 1'b1;
      b10.prod_num = 8'h7F;
      tick();
    end
    b10.in_valid = 1'b0;
    chk("t6_valid", b10.out_valid, 1);
    chk("t6_cnt",   b10.term_cnt,  16);
`ifdef SATURATE_EN
    chk("t6_acc", b10.acc_num, 10'h1FF);
    chk("t6_ovf", b10.ovf,     1);
`else
    chk("t6_acc", b10.acc_num, 10'h3F0);
    chk("t6_ovf", b10.ovf,     0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
